// File: rtl/aes_pkg.sv
// aes_pkg: mode encodings, FSM states and block/key widths shared by the AES
// mode-stream datapath and its helpers.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 256;

  typedef enum logic [1:0] {
    MODE_ECB = 2'd0,
    MODE_CBC = 2'd1,
    MODE_CTR = 2'd2,
    MODE_ILL = 2'd3
  } aes_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEY  = 3'd1,
    ST_IN   = 3'd2,
    ST_RUN  = 3'd3,
    ST_OUT  = 3'd4
  } aes_state_e;

endpackage

// File: rtl/aes_ctr_inc.sv
// aes_ctr_inc: increments the low CTR_W bits of a counter block modulo 2^CTR_W,
// passing the upper bits through unchanged.
module aes_ctr_inc
  import aes_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic [AES_BLK_W-1:0] blk,
  output logic [AES_BLK_W-1:0] blk_inc
);

  logic [CTR_W-1:0] low_inc;

  assign low_inc = blk[CTR_W-1:0] + CTR_W'(1);

  if (CTR_W < AES_BLK_W) begin : g_split
    assign blk_inc = {blk[AES_BLK_W-1:CTR_W], low_inc};
  end else begin : g_full
    assign blk_inc = low_inc;
  end

endmodule

// File: rtl/aes_mode_stream.sv
// aes_mode_stream: ECB/CBC/CTR mode sequencer around an external AES block
// engine, one block in flight, with IV chaining across multi-block messages.
module aes_mode_stream
  import aes_pkg::*;
#(
  parameter int CTR_W     = 32,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cfg_start,
  input  logic [1:0]           cfg_mode,
  input  logic                 cfg_encdec,
  input  logic                 cfg_keylen,
  input  logic                 cfg_rekey,
  input  logic [AES_KEY_W-1:0] cfg_key,
  input  logic [AES_BLK_W-1:0] cfg_iv,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [AES_BLK_W-1:0] s_data,
  input  logic                 s_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [AES_BLK_W-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 eng_init,
  output logic                 eng_next,
  output logic                 eng_encdec,
  output logic                 eng_keylen,
  output logic [AES_KEY_W-1:0] eng_key,
  output logic [AES_BLK_W-1:0] eng_block,
  input  logic                 eng_key_valid,
  input  logic                 eng_result_valid,
  input  logic [AES_BLK_W-1:0] eng_result
);

  aes_state_e           state, state_nxt;
  aes_mode_e            mode_q;
  logic                 encdec_q;
  logic                 keylen_q;
  logic [AES_KEY_W-1:0] key_q;
  logic [AES_BLK_W-1:0] chain_reg;
  logic [AES_BLK_W-1:0] data_q;
  logic                 last_q;
  logic [AES_BLK_W-1:0] ctr_next;

  aes_ctr_inc #(.CTR_W(CTR_W)) u_ctr_inc (
    .blk     (chain_reg),
    .blk_inc (ctr_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // The engine may still report a stale key_valid during the init pulse cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (cfg_start && (cfg_mode != MODE_ILL)) state_nxt = cfg_rekey ? ST_KEY : ST_IN;
      ST_KEY:  if (!eng_init && eng_key_valid) state_nxt = ST_IN;
      ST_IN:   if (s_valid) state_nxt = ST_RUN;
      ST_RUN:  if (eng_result_valid) state_nxt = ST_OUT;
      ST_OUT:  if (m_ready) state_nxt = last_q ? ST_IDLE : ST_IN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign s_ready    = (state == ST_IN);
  assign m_valid    = (state == ST_OUT);
  assign busy       = (state != ST_IDLE);
  assign eng_key    = key_q;
  assign eng_keylen = keylen_q;
  assign eng_encdec = (mode_q == MODE_CTR) ? 1'b1 : encdec_q;

  always_comb begin
    eng_block = data_q;
    case (mode_q)
      MODE_CBC: if (encdec_q) eng_block = data_q ^ chain_reg;
      MODE_CTR: eng_block = chain_reg;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q    <= MODE_ECB;
      encdec_q  <= 1'b0;
      keylen_q  <= 1'b0;
      key_q     <= '0;
      chain_reg <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      blk_cnt   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      eng_init  <= 1'b0;
      eng_next  <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      eng_init <= 1'b0;
      eng_next <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            if (cfg_mode == MODE_ILL) begin
              err <= 1'b1;
            end else begin
              mode_q    <= aes_mode_e'(cfg_mode);
              encdec_q  <= cfg_encdec;
              keylen_q  <= cfg_keylen;
              key_q     <= cfg_key;
              chain_reg <= cfg_iv;
              blk_cnt   <= '0;
              eng_init  <= cfg_rekey;
            end
          end
        end
        ST_IN: begin
          if (s_valid) begin
            data_q   <= s_data;
            last_q   <= s_last;
            eng_next <= 1'b1;
          end
        end
        // CBC decrypt chains on the ciphertext just consumed, not on the result.
        ST_RUN: begin
          if (eng_result_valid) begin
            m_last <= last_q;
            case (mode_q)
              MODE_CBC: begin
                if (encdec_q) begin
                  m_data    <= eng_result;
                  chain_reg <= eng_result;
                end else begin
                  m_data    <= eng_result ^ chain_reg;
                  chain_reg <= data_q;
                end
              end
              MODE_CTR: begin
                m_data    <= data_q ^ eng_result;
                chain_reg <= ctr_next;
              end
              default: m_data <= eng_result;
            endcase
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            blk_cnt <= blk_cnt + BLK_CNT_W'(1);
            done    <= last_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_mode_stream.sv
// tb_aes_mode_stream: scoreboard bench for aes_mode_stream driven through a
// behavioural engine stub (known-answer table plus a reversible toy cipher).
module tb_aes_mode_stream;
  import aes_pkg::*;

  localparam int TMO     = 200;
  localparam int ENG_LAT = 3;
  localparam int KEY_LAT = 5;

  localparam logic [127:0] KEY_FIPS = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY_NIST = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_SEQ   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_FIPS  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_FIPS  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1      = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PT2      = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CBC_CT1  = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_CT2  = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CTR_IV   = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] CTR_IV2  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00;
  localparam logic [127:0] CTR_CT1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] WRAP_IV  = 128'h0011223344556677_8899aabbffffffff;
  localparam logic [127:0] WRAP_IV2 = 128'h0011223344556677_8899aabb00000000;
  localparam logic [127:0] KEY_TOY  = 128'h1234567890abcdef_fedcba0987654321;

  // Known encryptions the engine stub answers exactly (engine-side in/out blocks).
  logic [127:0] kat_in [4] = '{PT_FIPS, 128'h6bc0bce12a459991e134741a7f9e1925,
                               128'hd86421fb9f1a1eda505ee1375746972c, CTR_IV};
  logic [127:0] kat_out[4] = '{CT_FIPS, CBC_CT1, CBC_CT2,
                               128'hec8cdf7398607cb0f2d21675ea9ea1e4};

  typedef struct {
    logic [127:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         cfg_start, cfg_encdec, cfg_keylen, cfg_rekey;
  logic [1:0]   cfg_mode;
  logic [255:0] cfg_key;
  logic [127:0] cfg_iv;
  logic         s_valid, s_ready, s_last;
  logic [127:0] s_data;
  logic         m_valid, m_ready, m_last;
  logic [127:0] m_data;
  logic         busy, done, err;
  logic [15:0]  blk_cnt;
  logic         eng_init, eng_next, eng_encdec, eng_keylen;
  logic [255:0] eng_key;
  logic [127:0] eng_block;
  logic         eng_key_valid, eng_result_valid;
  logic [127:0] eng_result;

  exp_t         exp_q[$];
  int           vectors     = 0;
  int           miscompares = 0;
  int           init_cnt    = 0;
  logic         spur;
  logic         eng_pend, eng_enc_q;
  int           eng_lat_cnt, key_cnt;
  logic [127:0] eng_blk_q, eng_k_q, last_eng_block;

  always #5 clk = ~clk;

  aes_mode_stream #(.CTR_W(32), .BLK_CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_encdec(cfg_encdec),
    .cfg_keylen(cfg_keylen), .cfg_rekey(cfg_rekey), .cfg_key(cfg_key), .cfg_iv(cfg_iv),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .err(err), .blk_cnt(blk_cnt),
    .eng_init(eng_init), .eng_next(eng_next), .eng_encdec(eng_encdec),
    .eng_keylen(eng_keylen), .eng_key(eng_key), .eng_block(eng_block),
    .eng_key_valid(eng_key_valid), .eng_result_valid(eng_result_valid),
    .eng_result(eng_result)
  );

  function automatic logic [127:0] toy_enc(input logic [127:0] b, input logic [127:0] k);
    return {b[119:0], b[127:120]} ^ k;
  endfunction

  function automatic logic [127:0] toy_dec(input logic [127:0] b, input logic [127:0] k);
    logic [127:0] t;
    t = b ^ k;
    return {t[7:0], t[127:8]};
  endfunction

  function automatic logic [127:0] engine_fn(input logic enc, input logic [127:0] b,
                                             input logic [127:0] k);
    for (int i = 0; i < 4; i++) begin
      if (enc && b == kat_in[i]) return kat_out[i];
      if (!enc && b == kat_out[i]) return kat_in[i];
    end
    return enc ? toy_enc(b, k) : toy_dec(b, k);
  endfunction

  // Engine stub: fixed key-expansion and block latency, optional stray result pulse.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      eng_key_valid    <= 1'b0;
      eng_result_valid <= 1'b0;
      eng_result       <= '0;
      eng_pend         <= 1'b0;
      eng_lat_cnt      <= 0;
      key_cnt          <= 0;
    end else begin
      eng_result_valid <= 1'b0;
      if (eng_init) begin
        eng_key_valid <= 1'b0;
        key_cnt       <= KEY_LAT;
        init_cnt      <= init_cnt + 1;
      end else if (key_cnt != 0) begin
        key_cnt <= key_cnt - 1;
        if (key_cnt == 1) eng_key_valid <= 1'b1;
      end
      if (eng_next) begin
        eng_pend       <= 1'b1;
        eng_lat_cnt    <= ENG_LAT;
        eng_blk_q      <= eng_block;
        eng_enc_q      <= eng_encdec;
        eng_k_q        <= eng_key[127:0];
        last_eng_block <= eng_block;
      end else if (eng_pend) begin
        if (eng_lat_cnt == 1) begin
          eng_pend         <= 1'b0;
          eng_result_valid <= 1'b1;
          eng_result       <= engine_fn(eng_enc_q, eng_blk_q, eng_k_q);
        end else begin
          eng_lat_cnt <= eng_lat_cnt - 1;
        end
      end
      if (spur) begin
        eng_result_valid <= 1'b1;
        eng_result       <= 128'hdeadbeef_cafef00d_01234567_89abcdef;
      end
    end
  end

  task automatic start_msg(input logic [1:0] mode, input logic encdec, input logic keylen,
                           input logic rekey, input logic [255:0] key, input logic [127:0] iv);
    cfg_mode   = mode;
    cfg_encdec = encdec;
    cfg_keylen = keylen;
    cfg_rekey  = rekey;
    cfg_key    = key;
    cfg_iv     = iv;
    cfg_start  = 1'b1;
    @(negedge clk);
    cfg_start  = 1'b0;
  endtask

  task automatic send_only(input logic [127:0] din, input logic dlast, output bit ok);
    int n;
    n = 0;
    while (s_ready !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    ok = (s_ready === 1'b1);
    if (ok) begin
      s_valid = 1'b1;
      s_data  = din;
      s_last  = dlast;
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_out(output bit ok);
    int n;
    n = 0;
    while (m_valid !== 1'b1 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    ok = (m_valid === 1'b1);
  endtask

  task automatic xfer_block(input logic [127:0] din, input logic dlast,
                            output logic [127:0] dout, output logic olast, output bit ok);
    dout  = '0;
    olast = 1'b0;
    send_only(din, dlast, ok);
    if (ok) wait_out(ok);
    if (ok) begin
      dout    = m_data;
      olast   = m_last;
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, s_ready, m_valid, m_last, done, err, eng_init, eng_next} !== 8'h00) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000000",
               {busy, s_ready, m_valid, m_last, done, err, eng_init, eng_next});
    end
    vectors++;
    if (m_data !== '0 || blk_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: m_data %h blk_cnt %0d, want 0/0", m_data, blk_cnt);
    end
    vectors++;
    if ({eng_block, eng_key, eng_encdec, eng_keylen} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_eng: eng_block %h eng_encdec %b eng_keylen %b, want zeros",
               eng_block, eng_encdec, eng_keylen);
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ecb();
    logic [127:0] dout;
    logic         olast;
    bit           ok;
    exp_t         e;
    int           init0;
    init0 = init_cnt;
    start_msg(MODE_ECB, 1'b1, 1'b0, 1'b1, {128'h0, KEY_FIPS}, '0);
    vectors++;
    if (eng_init !== 1'b1 || busy !== 1'b1 || eng_keylen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ecb_init: eng_init %b busy %b keylen %b, want 1 1 0", eng_init, busy, eng_keylen);
    end
    e.data = CT_FIPS;
    e.last = 1'b1;
    exp_q.push_back(e);
    xfer_block(PT_FIPS, 1'b1, dout, olast, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || {olast, dout} !== {e.last, e.data}) begin
      miscompares++;
      $display("[TB] FAIL ecb_data: got %h last %b, want %h last %b (ok=%0d)", dout, olast, e.data, e.last, ok);
    end
    vectors++;
    if (done !== 1'b1 || blk_cnt !== 16'd1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ecb_done: done %b blk_cnt %0d busy %b, want 1 1 0", done, blk_cnt, busy);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || init_cnt !== init0 + 1) begin
      miscompares++;
      $display("[TB] FAIL ecb_pulse: done %b init pulses %0d, want 0 and 1", done, init_cnt - init0);
    end
  endtask

  task automatic test_cbc(input logic encdec);
    logic [127:0] din[2], dexp[2], dout;
    logic         olast;
    bit           ok;
    exp_t         e;
    int           init0;
    din[0]  = encdec ? PT1 : CBC_CT1;
    din[1]  = encdec ? PT2 : CBC_CT2;
    dexp[0] = encdec ? CBC_CT1 : PT1;
    dexp[1] = encdec ? CBC_CT2 : PT2;
    init0   = init_cnt;
    start_msg(MODE_CBC, encdec, 1'b0, encdec, {128'h0, KEY_NIST}, IV_SEQ);
    for (int i = 0; i < 2; i++) begin
      e.data = dexp[i];
      e.last = (i == 1);
      exp_q.push_back(e);
      xfer_block(din[i], i == 1, dout, olast, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || {olast, dout} !== {e.last, e.data}) begin
        miscompares++;
        $display("[TB] FAIL cbc%s[%0d]: got %h last %b, want %h last %b (ok=%0d)",
                 encdec ? "enc" : "dec", i, dout, olast, e.data, e.last, ok);
      end
      vectors++;
      if (blk_cnt !== 16'(i + 1) || done !== (i == 1)) begin
        miscompares++;
        $display("[TB] FAIL cbc_cnt[%0d]: blk_cnt %0d done %b, want %0d %b", i, blk_cnt, done, i + 1, i == 1);
      end
    end
    vectors++;
    if (init_cnt !== init0 + (encdec ? 1 : 0)) begin
      miscompares++;
      $display("[TB] FAIL cbc_init: %0d init pulses, want %0d", init_cnt - init0, encdec ? 1 : 0);
    end
  endtask

  task automatic test_ctr();
    logic [127:0] din[2], ctr[2], dout;
    logic         olast;
    bit           ok;
    exp_t         e;
    // NIST vector first, with a stray engine result pulse while waiting for input.
    start_msg(MODE_CTR, 1'b0, 1'b0, 1'b1, {128'h0, KEY_NIST}, CTR_IV);
    e.data = CTR_CT1;
    e.last = 1'b0;
    exp_q.push_back(e);
    xfer_block(PT1, 1'b0, dout, olast, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || {olast, dout} !== {e.last, e.data}) begin
      miscompares++;
      $display("[TB] FAIL ctr_nist: got %h last %b, want %h last %b (ok=%0d)", dout, olast, e.data, e.last, ok);
    end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    vectors++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ctr_spurious: s_ready %b m_valid %b, want 1 0", s_ready, m_valid);
    end
    e.data = PT2 ^ toy_enc(CTR_IV2, KEY_NIST);
    e.last = 1'b1;
    exp_q.push_back(e);
    xfer_block(PT2, 1'b1, dout, olast, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || {olast, dout} !== {e.last, e.data} || last_eng_block !== CTR_IV2) begin
      miscompares++;
      $display("[TB] FAIL ctr_next: got %h ctr %h, want %h ctr %h (ok=%0d)",
               dout, last_eng_block, e.data, CTR_IV2, ok);
    end
    // Low-word wrap: upper 96 bits must survive.
    ctr[0] = WRAP_IV;
    ctr[1] = WRAP_IV2;
    din[0] = {$urandom, $urandom, $urandom, $urandom};
    din[1] = {$urandom, $urandom, $urandom, $urandom};
    start_msg(MODE_CTR, 1'b1, 1'b0, 1'b0, {128'h0, KEY_TOY}, WRAP_IV);
    for (int i = 0; i < 2; i++) begin
      e.data = din[i] ^ toy_enc(ctr[i], KEY_TOY);
      e.last = (i == 1);
      exp_q.push_back(e);
      xfer_block(din[i], i == 1, dout, olast, ok);
      e = exp_q.pop_front();
      vectors++;
      if (!ok || {olast, dout} !== {e.last, e.data} || last_eng_block !== ctr[i]) begin
        miscompares++;
        $display("[TB] FAIL ctr_wrap[%0d]: got %h ctr %h, want %h ctr %h (ok=%0d)",
                 i, dout, last_eng_block, e.data, ctr[i], ok);
      end
    end
  endtask

  task automatic test_stall_and_illegal();
    logic [127:0] din;
    bit           ok;
    exp_t         e;
    int           bad;
    din = {$urandom, $urandom, $urandom, $urandom};
    start_msg(MODE_ECB, 1'b1, 1'b1, 1'b0, {128'hffeeddccbbaa99887766554433221100, KEY_TOY}, '0);
    vectors++;
    if (eng_keylen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stall_keylen: got %b want 1", eng_keylen);
    end
    e.data = toy_enc(din, KEY_TOY);
    e.last = 1'b1;
    exp_q.push_back(e);
    send_only(din, 1'b1, ok);
    if (ok) wait_out(ok);
    e = exp_q.pop_front();
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if (!ok || m_valid !== 1'b1 || s_ready !== 1'b0 || m_data !== e.data || m_last !== 1'b1) begin
        miscompares++;
        bad++;
        if (bad < 4)
          $display("[TB] FAIL stall[%0d]: m_valid %b s_ready %b m_data %h, want 1 0 %h (ok=%0d)",
                   c, m_valid, s_ready, m_data, e.data, ok);
      end
      @(negedge clk);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL stall_done: done %b busy %b, want 1 0", done, busy);
    end
    start_msg(2'd3, 1'b1, 1'b0, 1'b1, '0, '0);
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0 || eng_init !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_err: err %b busy %b eng_init %b, want 1 0 0", err, busy, eng_init);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_pulse: err %b busy %b, want 0 0", err, busy);
    end
  endtask

  task automatic test_reset_mid_message();
    logic [127:0] dout;
    logic         olast;
    bit           ok;
    exp_t         e;
    start_msg(MODE_ECB, 1'b1, 1'b0, 1'b0, {128'h0, KEY_TOY}, '0);
    send_only(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0, 1'b1, ok);
    @(negedge clk);
    vectors++;
    if (!ok || busy !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_run: busy %b s_ready %b m_valid %b, want 1 0 0 (ok=%0d)",
               busy, s_ready, m_valid, ok);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({busy, s_ready, m_valid, m_last, done, err, eng_init, eng_next} !== 8'h00 ||
        m_data !== '0 || blk_cnt !== '0 || eng_block !== '0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: ctrl %b m_data %h blk_cnt %0d, want zeros",
               {busy, s_ready, m_valid, m_last, done, err, eng_init, eng_next}, m_data, blk_cnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (ENG_LAT + 3) @(negedge clk);
    vectors++;
    if (m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_ghost: m_valid %b done %b busy %b, want 0 0 0", m_valid, done, busy);
    end
    start_msg(MODE_ECB, 1'b1, 1'b0, 1'b1, {128'h0, KEY_FIPS}, '0);
    e.data = CT_FIPS;
    e.last = 1'b1;
    exp_q.push_back(e);
    xfer_block(PT_FIPS, 1'b1, dout, olast, ok);
    e = exp_q.pop_front();
    vectors++;
    if (!ok || {olast, dout} !== {e.last, e.data} || done !== 1'b1 || blk_cnt !== 16'd1) begin
      miscompares++;
      $display("[TB] FAIL mid_recover: got %h done %b blk_cnt %0d, want %h 1 1 (ok=%0d)",
               dout, done, blk_cnt, e.data, ok);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    cfg_start  = 1'b0;
    cfg_mode   = 2'd0;
    cfg_encdec = 1'b0;
    cfg_keylen = 1'b0;
    cfg_rekey  = 1'b0;
    cfg_key    = '0;
    cfg_iv     = '0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_last     = 1'b0;
    m_ready    = 1'b0;
    spur       = 1'b0;
    test_reset();
    test_ecb();
    test_cbc(1'b1);
    test_cbc(1'b0);
    test_ctr();
    test_stall_and_illegal();
    test_reset_mid_message();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: run still active at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
